// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller and the
// pipeline register modules it steers.
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    MDIV_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline status in, stage hold/flush/bubble out.
// The pipeline side is master, the controller is slave.
interface pipeline_hazard_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           ID_ADDR1;
  logic [4:0]           ID_ADDR2;
  logic                 ID_USES1;
  logic                 ID_USES2;
  logic [4:0]           EXE_ADDR;
  logic                 EXE_MEMREAD;
  logic                 EXE_MDIV;
  logic                 MDIV_DONE;
  logic                 BRANCH_TAKEN;
  logic                 IMEM_BUSYWAIT;
  logic                 DMEM_BUSYWAIT;
  logic                 PC_HOLD;
  logic                 IF_ID_HOLD;
  logic                 ID_EXE_HOLD;
  logic                 EXE_MEM_HOLD;
  logic                 MEM_WB_HOLD;
  logic                 IF_ID_FLUSH;
  logic                 ID_EXE_BUBBLE;
  logic                 EXE_MEM_BUBBLE;
  logic                 MDIV_START;
  logic                 MDIV_TIMEOUT;
  logic [CNT_WIDTH-1:0] STALL_CYCLES;

  modport master (
    output ID_ADDR1, ID_ADDR2, ID_USES1, ID_USES2, EXE_ADDR, EXE_MEMREAD,
           EXE_MDIV, MDIV_DONE, BRANCH_TAKEN, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
    input  PC_HOLD, IF_ID_HOLD, ID_EXE_HOLD, EXE_MEM_HOLD, MEM_WB_HOLD,
           IF_ID_FLUSH, ID_EXE_BUBBLE, EXE_MEM_BUBBLE, MDIV_START,
           MDIV_TIMEOUT, STALL_CYCLES
  );

  modport slave (
    input  ID_ADDR1, ID_ADDR2, ID_USES1, ID_USES2, EXE_ADDR, EXE_MEMREAD,
           EXE_MDIV, MDIV_DONE, BRANCH_TAKEN, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
    output PC_HOLD, IF_ID_HOLD, ID_EXE_HOLD, EXE_MEM_HOLD, MEM_WB_HOLD,
           IF_ID_FLUSH, ID_EXE_BUBBLE, EXE_MEM_BUBBLE, MDIV_START,
           MDIV_TIMEOUT, STALL_CYCLES
  );

endinterface

// File: rtl/pipeline_hazard_controller_hazard_match.sv
// Source-register vs destination-register compare; x0 is never a producer.
module hazard_match
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_i,
  input  logic       use_i,
  output logic       match_o
);

  assign match_o = use_i && (rd_i != REG_ZERO) && (rs_i == rd_i);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, DIV/REM occupancy,
// taken-branch redirect and memory busywait, plus watchdog and stall counter.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MDIV_MAX_CYCLES = 40,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  pipeline_hazard_controller_if.slave  bus
);

  localparam int               WD_W   = $clog2(MDIV_MAX_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_MAX = WD_W'(MDIV_MAX_CYCLES);

  hz_state_e            state_q, state_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic match1, match2, load_use, freeze;
  logic pc_hold, if_id_hold, id_exe_hold, exe_mem_hold, mem_wb_hold;
  logic if_id_flush, id_exe_bubble, exe_mem_bubble, mdiv_start;

  hazard_match u_match_rs1 (
    .rs_i    (bus.ID_ADDR1),
    .rd_i    (bus.EXE_ADDR),
    .use_i   (bus.ID_USES1),
    .match_o (match1)
  );

  hazard_match u_match_rs2 (
    .rs_i    (bus.ID_ADDR2),
    .rd_i    (bus.EXE_ADDR),
    .use_i   (bus.ID_USES2),
    .match_o (match2)
  );

  assign load_use = bus.EXE_MEMREAD && (match1 || match2);
  assign freeze   = bus.IMEM_BUSYWAIT || bus.DMEM_BUSYWAIT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A frozen pipeline keeps its registers, so the FSM must not move either.
  always_comb begin
    state_d = state_q;
    if (!freeze) begin
      case (state_q)
        RUN:       if (bus.EXE_MDIV)  state_d = MDIV_WAIT;
        MDIV_WAIT: if (bus.MDIV_DONE) state_d = RUN;
        default:   state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_hold        = 1'b0;
    if_id_hold     = 1'b0;
    id_exe_hold    = 1'b0;
    exe_mem_hold   = 1'b0;
    mem_wb_hold    = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_bubble  = 1'b0;
    exe_mem_bubble = 1'b0;
    mdiv_start     = 1'b0;
    if (RESET) begin
      pc_hold = 1'b0;
    end else if (freeze) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_exe_hold  = 1'b1;
      exe_mem_hold = 1'b1;
      mem_wb_hold  = 1'b1;
    end else if (state_q == MDIV_WAIT) begin
      if (!bus.MDIV_DONE) begin
        pc_hold        = 1'b1;
        if_id_hold     = 1'b1;
        id_exe_hold    = 1'b1;
        exe_mem_bubble = 1'b1;
      end
    end else if (bus.EXE_MDIV) begin
      mdiv_start     = 1'b1;
      pc_hold        = 1'b1;
      if_id_hold     = 1'b1;
      id_exe_hold    = 1'b1;
      exe_mem_bubble = 1'b1;
    end else if (bus.BRANCH_TAKEN) begin
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
    end else if (load_use) begin
      pc_hold       = 1'b1;
      if_id_hold    = 1'b1;
      id_exe_bubble = 1'b1;
    end
  end

  // Watchdog counts only cycles the divider could actually make progress in.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (!freeze) begin
      if (state_q == RUN && bus.EXE_MDIV) begin
        wd_d = '0;
      end else if (state_q == MDIV_WAIT && wd_q != WD_MAX) begin
        wd_d = wd_q + WD_W'(1);
      end
    end
    if (wd_d == WD_MAX) timeout_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pc_hold && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PC_HOLD        = pc_hold;
  assign bus.IF_ID_HOLD     = if_id_hold;
  assign bus.ID_EXE_HOLD    = id_exe_hold;
  assign bus.EXE_MEM_HOLD   = exe_mem_hold;
  assign bus.MEM_WB_HOLD    = mem_wb_hold;
  assign bus.IF_ID_FLUSH    = if_id_flush;
  assign bus.ID_EXE_BUBBLE  = id_exe_bubble;
  assign bus.EXE_MEM_BUBBLE = exe_mem_bubble;
  assign bus.MDIV_START     = mdiv_start;
  assign bus.MDIV_TIMEOUT   = RESET ? 1'b0 : timeout_q;
  assign bus.STALL_CYCLES   = RESET ? '0 : cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: RUN-state vector table plus
// divide, freeze, watchdog, reset and counter-saturation sequences.
module tb_pipeline_hazard_controller;

  logic CLK = 1'b0;
  logic RESET;

  pipeline_hazard_controller_if #(.CNT_WIDTH(32)) bus ();
  pipeline_hazard_controller_if #(.CNT_WIDTH(4))  bus4 ();

  pipeline_hazard_controller #(.MDIV_MAX_CYCLES(40), .CNT_WIDTH(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  pipeline_hazard_controller #(.MDIV_MAX_CYCLES(40), .CNT_WIDTH(4)) dut4 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus4)
  );

  always #5 CLK = ~CLK;

  // ctl bit order: PC, IF_ID, ID_EXE, EXE_MEM, MEM_WB holds, IF_ID_FLUSH,
  // ID_EXE_BUBBLE, EXE_MEM_BUBBLE, MDIV_START
  localparam logic [8:0] C_NONE   = 9'b000000000;
  localparam logic [8:0] C_LDUSE  = 9'b110000100;
  localparam logic [8:0] C_BRANCH = 9'b000001100;
  localparam logic [8:0] C_FREEZE = 9'b111110000;
  localparam logic [8:0] C_START  = 9'b111000011;
  localparam logic [8:0] C_WAIT   = 9'b111000010;

  typedef struct {
    logic [4:0] exe_addr;
    logic [4:0] a1;
    logic [4:0] a2;
    logic       u1;
    logic       u2;
    logic       memread;
    logic       branch;
    logic       imem;
    logic       dmem;
    logic       done;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [12];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_cnt;
  int   w;
  logic frz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {bus.PC_HOLD, bus.IF_ID_HOLD, bus.ID_EXE_HOLD, bus.EXE_MEM_HOLD,
            bus.MEM_WB_HOLD, bus.IF_ID_FLUSH, bus.ID_EXE_BUBBLE,
            bus.EXE_MEM_BUBBLE, bus.MDIV_START};
  endfunction

  task automatic idle();
    bus.ID_ADDR1      = 5'd0;
    bus.ID_ADDR2      = 5'd0;
    bus.ID_USES1      = 1'b0;
    bus.ID_USES2      = 1'b0;
    bus.EXE_ADDR      = 5'd0;
    bus.EXE_MEMREAD   = 1'b0;
    bus.EXE_MDIV      = 1'b0;
    bus.MDIV_DONE     = 1'b0;
    bus.BRANCH_TAKEN  = 1'b0;
    bus.IMEM_BUSYWAIT = 1'b0;
    bus.DMEM_BUSYWAIT = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    idle();
    bus.EXE_ADDR      = v.exe_addr;
    bus.ID_ADDR1      = v.a1;
    bus.ID_ADDR2      = v.a2;
    bus.ID_USES1      = v.u1;
    bus.ID_USES2      = v.u2;
    bus.EXE_MEMREAD   = v.memread;
    bus.BRANCH_TAKEN  = v.branch;
    bus.IMEM_BUSYWAIT = v.imem;
    bus.DMEM_BUSYWAIT = v.dmem;
    bus.MDIV_DONE     = v.done;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    //          exe  a1   a2   u1 u2 mr br im dm dn  expected
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, C_NONE};
    vecs[1]  = '{5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0, 0, 0, C_LDUSE};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 0, C_NONE};
    vecs[3]  = '{5'd7, 5'd3, 5'd7, 0, 1, 1, 0, 0, 0, 0, C_LDUSE};
    vecs[4]  = '{5'd7, 5'd3, 5'd7, 1, 0, 1, 0, 0, 0, 0, C_NONE};
    vecs[5]  = '{5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, 0, 0, C_NONE};
    vecs[6]  = '{5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0, 0, 0, C_BRANCH};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, C_BRANCH};
    vecs[8]  = '{5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 1, 0, 0, C_FREEZE};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, C_FREEZE};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, C_NONE};
    vecs[11] = '{5'd5, 5'd6, 5'd4, 1, 1, 1, 0, 0, 0, 0, C_NONE};

    bus4.ID_ADDR1 = 5'd0; bus4.ID_ADDR2 = 5'd0; bus4.ID_USES1 = 1'b0;
    bus4.ID_USES2 = 1'b0; bus4.EXE_ADDR = 5'd0; bus4.EXE_MEMREAD = 1'b0;
    bus4.EXE_MDIV = 1'b0; bus4.MDIV_DONE = 1'b0; bus4.BRANCH_TAKEN = 1'b0;
    bus4.IMEM_BUSYWAIT = 1'b0; bus4.DMEM_BUSYWAIT = 1'b0;

    // Reset with a load-use and a divide present: nothing may assert.
    idle();
    RESET = 1'b1;
    bus.EXE_MEMREAD = 1'b1; bus.EXE_ADDR = 5'd5; bus.ID_ADDR1 = 5'd5;
    bus.ID_USES1 = 1'b1; bus.EXE_MDIV = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ctl", 32'(ctl()), 32'(C_NONE));
    chk("reset_cnt", bus.STALL_CYCLES, 32'd0);
    chk("reset_timeout", 32'(bus.MDIV_TIMEOUT), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    idle();
    exp_cnt = 0;

    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp));
      if (vecs[i].exp[8]) exp_cnt++;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_cnt", i), bus.STALL_CYCLES, 32'(exp_cnt));
    end

    // Divide: start, 33 wait cycles, then DONE releases the pipeline.
    @(negedge CLK);
    idle();
    bus.EXE_MDIV = 1'b1;
    #1;
    chk("div_start", 32'(ctl()), 32'(C_START));
    for (int k = 1; k <= 33; k++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("div_wait%0d", k), 32'(ctl()), 32'(C_WAIT));
    end
    @(negedge CLK);
    bus.MDIV_DONE = 1'b1;
    #1;
    chk("div_done", 32'(ctl()), 32'(C_NONE));
    @(negedge CLK);
    idle();
    bus.BRANCH_TAKEN = 1'b1;
    #1;
    exp_cnt += 34;
    chk("div_back_run", 32'(ctl()), 32'(C_BRANCH));
    chk("div_cnt", bus.STALL_CYCLES, 32'(exp_cnt));

    // Divide that never completes, with a 3-cycle freeze mid-wait.
    @(negedge CLK);
    idle();
    bus.EXE_MDIV = 1'b1;
    #1;
    chk("to_start", 32'(ctl()), 32'(C_START));
    exp_cnt++;
    w = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge CLK);
      frz = (k >= 20 && k < 23);
      bus.DMEM_BUSYWAIT = frz;
      bus.BRANCH_TAKEN  = (k % 2 == 1);
      #1;
      chk($sformatf("to_ctl%0d", k), 32'(ctl()), frz ? 32'(C_FREEZE) : 32'(C_WAIT));
      chk($sformatf("to_flag%0d", k), 32'(bus.MDIV_TIMEOUT), (w >= 40) ? 32'd1 : 32'd0);
      if (!frz) w++;
      exp_cnt++;
    end
    @(negedge CLK);
    #1;
    chk("to_cnt", bus.STALL_CYCLES, 32'(exp_cnt));
    chk("to_sticky", 32'(bus.MDIV_TIMEOUT), 32'd1);

    // One-cycle reset out of MDIV_WAIT.
    RESET = 1'b1;
    bus.BRANCH_TAKEN  = 1'b0;
    bus.DMEM_BUSYWAIT = 1'b0;
    #1;
    chk("rst_wait_ctl", 32'(ctl()), 32'(C_NONE));
    chk("rst_wait_flag", 32'(bus.MDIV_TIMEOUT), 32'd0);
    chk("rst_wait_cnt", bus.STALL_CYCLES, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    idle();
    bus.BRANCH_TAKEN = 1'b1;
    #1;
    chk("rst_run_ctl", 32'(ctl()), 32'(C_BRANCH));
    chk("rst_run_flag", 32'(bus.MDIV_TIMEOUT), 32'd0);
    chk("rst_run_cnt", bus.STALL_CYCLES, 32'd0);
    @(negedge CLK);
    idle();

    // Narrow counter saturates at 15.
    bus4.IMEM_BUSYWAIT = 1'b1;
    #1;
    chk("sat_hold", 32'(bus4.PC_HOLD), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("sat_cnt%0d", k), 32'(bus4.STALL_CYCLES), (k < 15) ? 32'(k) : 32'd15);
    end
    bus4.IMEM_BUSYWAIT = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
